// File: rtl/lms_err_if.sv
// Complex LMS error sample bus from the error/subtract stage.
// One sample per cycle when e_vld is high; gaps allowed.
interface lms_err_if;
  logic [15:0] e_i;
  logic [15:0] e_q;
  logic        e_vld;

  modport master (
    output e_i,
    output e_q,
    output e_vld
  );

  modport slave (
    input e_i,
    input e_q,
    input e_vld
  );
endinterface

// File: rtl/lms_err_monitor.sv
// LMS error monitor: mean |e|^2 over 16-sample blocks and a
// convergence FSM driving step-size shift and weight freeze.
module lms_err_monitor #(
  parameter logic [31:0] THR_LO   = 32'd1024,
  parameter logic [31:0] THR_HI   = 32'd16384,
  parameter logic [31:0] THR_DIV  = 32'd268435456,
  parameter int          CONV_CNT = 4,
  parameter int          MU_ACQ   = 4,
  parameter int          MU_TRK   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  lms_err_if.slave    err,
  output logic [31:0] blk_pwr,
  output logic        pwr_vld,
  output logic [1:0]  state,
  output logic [3:0]  mu_shift,
  output logic        freeze
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    DIV   = 2'd2
  } st_t;

  localparam logic [3:0] CONV  = 4'(CONV_CNT);
  localparam logic [3:0] MU_A  = 4'(MU_ACQ);
  localparam logic [3:0] MU_T  = 4'(MU_TRK);

  logic signed [15:0] ei_s;
  logic signed [15:0] eq_s;
  logic signed [31:0] ei_x;
  logic signed [31:0] eq_x;
  logic signed [31:0] sqi_w;
  logic signed [31:0] sqq_w;

  logic        v1;
  logic [31:0] sq_i;
  logic [31:0] sq_q;
  logic        v2;
  logic [31:0] p;
  logic [35:0] acc;
  logic [35:0] sum_w;
  logic [3:0]  cnt;

  st_t         st;
  logic [1:0]  div_cnt;
  logic [3:0]  lo_cnt;
  logic        is_div;
  logic        is_lo;
  logic        is_hi;
  logic        below_hi;

  // Full 32-bit squares; |x|^2 <= 2^30 so a 32-bit product is exact.
  assign ei_s  = err.e_i;
  assign eq_s  = err.e_q;
  assign ei_x  = 32'(ei_s);
  assign eq_x  = 32'(eq_s);
  assign sqi_w = ei_x * ei_x;
  assign sqq_w = eq_x * eq_x;

  assign sum_w    = acc + 36'(p);
  assign is_div   = blk_pwr >= THR_DIV;
  assign is_lo    = blk_pwr < THR_LO;
  assign is_hi    = blk_pwr > THR_HI;
  assign below_hi = blk_pwr < THR_HI;
  assign state    = st;

  // S1: register the squared I and Q components.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      sq_i <= '0;
      sq_q <= '0;
    end else if (clear) begin
      v1   <= 1'b0;
      sq_i <= '0;
      sq_q <= '0;
    end else begin
      v1 <= err.e_vld;
      if (err.e_vld) begin
        sq_i <= sqi_w;
        sq_q <= sqq_w;
      end
    end
  end

  // S2: instantaneous power |e|^2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2 <= 1'b0;
      p  <= '0;
    end else if (clear) begin
      v2 <= 1'b0;
      p  <= '0;
    end else begin
      v2 <= v1;
      if (v1) p <= sq_i + sq_q;
    end
  end

  // S3: block accumulator; 16th sample publishes the mean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      blk_pwr <= '0;
      pwr_vld <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      cnt     <= '0;
      blk_pwr <= '0;
      pwr_vld <= 1'b0;
    end else begin
      pwr_vld <= 1'b0;
      if (v2) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          blk_pwr <= sum_w[35:4];
          pwr_vld <= 1'b1;
          acc     <= '0;
        end else begin
          acc <= sum_w;
        end
      end
    end
  end

  // Convergence FSM, stepped once per published block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ACQ;
      div_cnt  <= '0;
      lo_cnt   <= '0;
      mu_shift <= MU_A;
      freeze   <= 1'b0;
    end else if (clear) begin
      st       <= ACQ;
      div_cnt  <= '0;
      lo_cnt   <= '0;
      mu_shift <= MU_A;
      freeze   <= 1'b0;
    end else if (pwr_vld) begin
      if (is_div)
        div_cnt <= (div_cnt == 2'd2) ? 2'd2 : div_cnt + 2'd1;
      else
        div_cnt <= '0;
      if (is_lo)
        lo_cnt <= (lo_cnt == CONV) ? CONV : lo_cnt + 4'd1;
      else
        lo_cnt <= '0;
      if (is_div && div_cnt == 2'd1) begin
        st       <= DIV;
        mu_shift <= MU_A;
        freeze   <= 1'b1;
      end else begin
        unique case (st)
          ACQ: begin
            if (is_lo && lo_cnt == CONV - 4'd1) begin
              st       <= TRACK;
              mu_shift <= MU_T;
              freeze   <= 1'b0;
            end
          end
          TRACK: begin
            if (is_hi) begin
              st       <= ACQ;
              lo_cnt   <= '0;
              mu_shift <= MU_A;
            end
          end
          DIV: begin
            if (below_hi) begin
              st       <= ACQ;
              div_cnt  <= '0;
              lo_cnt   <= '0;
              mu_shift <= MU_A;
              freeze   <= 1'b0;
            end
          end
          default: begin
            st       <= ACQ;
            mu_shift <= MU_A;
            freeze   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lms_err_monitor.sv
// Directed bench for lms_err_monitor: block power, latency,
// convergence FSM, divergence freeze, reset and clear flush.
module tb_lms_err_monitor;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [31:0] blk_pwr;
  logic        pwr_vld;
  logic [1:0]  state;
  logic [3:0]  mu_shift;
  logic        freeze;

  int nvec = 0;
  int nerr = 0;

  lms_err_if eif ();

  lms_err_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .err      (eif),
    .blk_pwr  (blk_pwr),
    .pwr_vld  (pwr_vld),
    .state    (state),
    .mu_shift (mu_shift),
    .freeze   (freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [15:0] v, input int gap);
    for (int s = 0; s < 16; s++) begin
      repeat (gap) begin
        @(negedge clk);
        eif.e_vld = 1'b0;
      end
      @(negedge clk);
      eif.e_i   = v;
      eif.e_q   = v;
      eif.e_vld = 1'b1;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      eif.e_vld = 1'b0;
      if (pwr_vld) begin
        n = c;
        break;
      end
    end
    if (n == 0) n = 99;
  endtask

  task automatic test_reset;
    #12;
    nvec++;
    if (blk_pwr !== 32'd0) begin
      nerr++;
      $display("FAIL rst_blk: got %0d expected 0", blk_pwr);
    end
    nvec++;
    if (pwr_vld !== 1'b0 || state !== 2'd0 || freeze !== 1'b0) begin
      nerr++;
      $display("FAIL rst_flags: got vld=%0b st=%0d frz=%0b expected 0 0 0",
               pwr_vld, state, freeze);
    end
    nvec++;
    if (mu_shift !== 4'd4) begin
      nerr++;
      $display("FAIL rst_mu: got %0d expected 4", mu_shift);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_gap;
    int n;
    send_block(16'd16, 1);
    wait_pulse(n);
    nvec++;
    if (n !== 3) begin
      nerr++;
      $display("FAIL gap_latency: got %0d expected 3", n);
    end
    nvec++;
    if (blk_pwr !== 32'd512) begin
      nerr++;
      $display("FAIL gap_pwr: got %0d expected 512", blk_pwr);
    end
    @(negedge clk);
    nvec++;
    if (pwr_vld !== 1'b0) begin
      nerr++;
      $display("FAIL gap_single: got %0b expected 0", pwr_vld);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (blk_pwr !== 32'd512 || pwr_vld !== 1'b0) begin
      nerr++;
      $display("FAIL gap_hold: got %0d/%0b expected 512/0",
               blk_pwr, pwr_vld);
    end
  endtask

  task automatic test_overflow;
    int n;
    send_block(16'h8000, 0);
    wait_pulse(n);
    nvec++;
    if (blk_pwr !== 32'h8000_0000) begin
      nerr++;
      $display("FAIL ovf_pwr: got %0d expected 2147483648", blk_pwr);
    end
    @(negedge clk);
    nvec++;
    if (state !== 2'd0 || freeze !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_single_div: got st=%0d frz=%0b expected 0 0",
               state, freeze);
    end
  endtask

  task automatic test_converge;
    int n;
    logic [1:0] exp_st;
    logic [3:0] exp_mu;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send_block(16'd8, 0);
      wait_pulse(n);
      nvec++;
      if (blk_pwr !== 32'd128) begin
        nerr++;
        $display("FAIL conv_pwr%0d: got %0d expected 128", b, blk_pwr);
      end
      @(negedge clk);
      exp_st = (b == 3) ? 2'd1 : 2'd0;
      exp_mu = (b == 3) ? 4'd8 : 4'd4;
      nvec++;
      if (state !== exp_st || mu_shift !== exp_mu) begin
        nerr++;
        $display("FAIL conv_st%0d: got st=%0d mu=%0d expected %0d %0d",
                 b, state, mu_shift, exp_st, exp_mu);
      end
    end
  endtask

  task automatic test_lost;
    int n;
    send_block(16'd100, 0);
    wait_pulse(n);
    nvec++;
    if (blk_pwr !== 32'd20000) begin
      nerr++;
      $display("FAIL lost_pwr: got %0d expected 20000", blk_pwr);
    end
    @(negedge clk);
    nvec++;
    if (state !== 2'd0 || mu_shift !== 4'd4) begin
      nerr++;
      $display("FAIL lost_st: got st=%0d mu=%0d expected 0 4",
               state, mu_shift);
    end
  endtask

  task automatic test_diverge;
    int n;
    send_block(16'd16384, 0);
    wait_pulse(n);
    nvec++;
    if (blk_pwr !== 32'd536870912) begin
      nerr++;
      $display("FAIL div_pwr: got %0d expected 536870912", blk_pwr);
    end
    @(negedge clk);
    nvec++;
    if (state !== 2'd0 || freeze !== 1'b0) begin
      nerr++;
      $display("FAIL div_first: got st=%0d frz=%0b expected 0 0",
               state, freeze);
    end
    send_block(16'd16384, 0);
    wait_pulse(n);
    @(negedge clk);
    nvec++;
    if (state !== 2'd2 || freeze !== 1'b1 || mu_shift !== 4'd4) begin
      nerr++;
      $display("FAIL div_enter: got st=%0d frz=%0b mu=%0d expected 2 1 4",
               state, freeze, mu_shift);
    end
    send_block(16'd0, 0);
    wait_pulse(n);
    nvec++;
    if (blk_pwr !== 32'd0) begin
      nerr++;
      $display("FAIL div_zero_pwr: got %0d expected 0", blk_pwr);
    end
    @(negedge clk);
    nvec++;
    if (state !== 2'd0 || freeze !== 1'b0) begin
      nerr++;
      $display("FAIL div_exit: got st=%0d frz=%0b expected 0 0",
               state, freeze);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int pulses;
    int pj;
    logic [31:0] pv;
    pulses = 0;
    pj     = -1;
    pv     = '0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (pwr_vld) begin
        pulses++;
        pj = j;
        pv = blk_pwr;
      end
      eif.e_i   = (j < 16) ? 16'd16 : 16'd8;
      eif.e_q   = eif.e_i;
      eif.e_vld = 1'b1;
    end
    nvec++;
    if (pulses !== 1 || pj !== 18) begin
      nerr++;
      $display("FAIL b2b_pulse: got n=%0d at %0d expected 1 at 18",
               pulses, pj);
    end
    nvec++;
    if (pv !== 32'd512) begin
      nerr++;
      $display("FAIL b2b_pwrA: got %0d expected 512", pv);
    end
    wait_pulse(n);
    nvec++;
    if (n !== 3 || blk_pwr !== 32'd128) begin
      nerr++;
      $display("FAIL b2b_pwrB: got lat=%0d pwr=%0d expected 3 128",
               n, blk_pwr);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      eif.e_i   = 16'd100;
      eif.e_q   = 16'd100;
      eif.e_vld = 1'b1;
    end
    #2;
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (blk_pwr !== 32'd0 || state !== 2'd0 || mu_shift !== 4'd4) begin
      nerr++;
      $display("FAIL rmid_regs: got pwr=%0d st=%0d mu=%0d expected 0 0 4",
               blk_pwr, state, mu_shift);
    end
    reset     = 1'b1;
    eif.e_vld = 1'b0;
    send_block(16'd16, 0);
    wait_pulse(n);
    nvec++;
    if (n !== 3 || blk_pwr !== 32'd512) begin
      nerr++;
      $display("FAIL rmid_pwr: got lat=%0d pwr=%0d expected 3 512",
               n, blk_pwr);
    end
  endtask

  task automatic test_clear_mid;
    int n;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      eif.e_i   = 16'd100;
      eif.e_q   = 16'd100;
      eif.e_vld = 1'b1;
    end
    @(negedge clk);
    clear     = 1'b1;
    eif.e_i   = 16'd200;
    eif.e_q   = 16'd200;
    eif.e_vld = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    eif.e_vld = 1'b0;
    nvec++;
    if (blk_pwr !== 32'd0 || pwr_vld !== 1'b0) begin
      nerr++;
      $display("FAIL cmid_regs: got pwr=%0d vld=%0b expected 0 0",
               blk_pwr, pwr_vld);
    end
    send_block(16'd16, 0);
    wait_pulse(n);
    nvec++;
    if (n !== 3 || blk_pwr !== 32'd512) begin
      nerr++;
      $display("FAIL cmid_pwr: got lat=%0d pwr=%0d expected 3 512",
               n, blk_pwr);
    end
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    eif.e_i   = '0;
    eif.e_q   = '0;
    eif.e_vld = 1'b0;
    test_reset();
    test_gap();
    test_overflow();
    test_converge();
    test_lost();
    test_diverge();
    test_back_to_back();
    test_reset_mid();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
